avalon_st_checker: RTL and testbench

AVALON_ST_CHECKER -- requirements
Module: avalon_st_checker

---
 rtl/avalon_st_checker.sv | 181 ++++++++++++++++++
 tb/tb_avalon_st_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_checker.sv
// Avalon-ST pattern checker: sinks beats of incrementing 16-bit lanes, counts bytes,
// errors and cycles, with optional throttling of ready and an Avalon-MM control slave.
module avalon_st_checker #(
  parameter int unsigned DATA_W = 256
) (
  input  logic              csi_clk_clk,
  input  logic              rsi_reset_reset_n,
  input  logic [3:0]        avs_ctrl_address,
  input  logic              avs_ctrl_read,
  input  logic              avs_ctrl_write,
  input  logic [31:0]       avs_ctrl_writedata,
  output logic [31:0]       avs_ctrl_readdata,
  input  logic [DATA_W-1:0] asi_data_data,
  input  logic              asi_data_valid,
  output logic              asi_data_ready
);

  localparam int unsigned NR_SYMS  = DATA_W / 8;
  localparam int unsigned NR_LANES = DATA_W / 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] scratch_q, scratch_d, target_q, target_d;
  logic [7:0]  p_q, p_d, thr_q, thr_d;
  logic [15:0] base_q, base_d;
  logic [31:0] rx_q, rx_d, err_q, err_d, first_q, first_d;
  logic [31:0] cyc_q, cyc_d, span_q, span_d, beat_q, beat_d;
  logic        active_q, active_d;
  logic [31:0] rdata_q, rdata_d;

  logic        start, stall, hs, accept, mismatch;
  logic [31:0] rx_inc, span_inc;

  assign start  = avs_ctrl_write && (avs_ctrl_address == 4'd5) && avs_ctrl_writedata[0];
  assign hs     = asi_data_ready && asi_data_valid;
  assign accept = hs && !start;
  assign rx_inc = rx_q + (hs ? 32'(NR_SYMS) : 32'd0);

  // FSM: state register
  always_ff @(posedge csi_clk_clk or negedge rsi_reset_reset_n) begin
    if (!rsi_reset_reset_n) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  // FSM: next state; target 0 falls through to DONE on the first RUN cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (rx_inc >= target_q) state_d = DONE;
      default: state_d = state_q;
    endcase
    if (start) state_d = RUN;
  end

  // FSM: outputs
  always_comb begin
    stall          = (p_q != '0) && (thr_q >= p_q);
    asi_data_ready = (state_q == RUN) && !stall && (rx_q < target_q);
  end

  always_comb begin
    mismatch = 1'b0;
    for (int unsigned i = 0; i < NR_LANES; i++) begin
      if (asi_data_data[16*i +: 16] != base_q + 16'(i)) mismatch = 1'b1;
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    target_d  = target_q;
    p_d       = p_q;
    thr_d     = thr_q;
    base_d    = base_q;
    rx_d      = rx_q;
    err_d     = err_q;
    first_d   = first_q;
    cyc_d     = cyc_q;
    span_d    = span_q;
    beat_d    = beat_q;
    active_d  = active_q;
    span_inc  = (span_q == '1) ? span_q : span_q + 32'd1;

    if (avs_ctrl_write) begin
      case (avs_ctrl_address)
        4'd3:    scratch_d = avs_ctrl_writedata;
        4'd6:    p_d       = avs_ctrl_writedata[7:0];
        4'd8:    target_d  = avs_ctrl_writedata;
        default: ;
      endcase
    end

    if (start) begin
      thr_d    = '0;
      base_d   = '0;
      rx_d     = '0;
      err_d    = '0;
      first_d  = '1;
      cyc_d    = '0;
      span_d   = '0;
      beat_d   = '0;
      active_d = 1'b0;
    end else if (state_q == RUN) begin
      if (stall)                          thr_d = '0;
      else if (asi_data_ready && p_q != '0) thr_d = thr_q + 8'd1;

      // span runs every RUN cycle after the first beat, cycle count snapshots it on each beat
      if (active_q) span_d = span_inc;
      if (accept) begin
        base_d = base_q + 16'(NR_LANES);
        rx_d   = rx_inc;
        beat_d = beat_q + 32'd1;
        if (!active_q) begin
          active_d = 1'b1;
          span_d   = 32'd1;
        end
        cyc_d = span_d;
        if (mismatch) begin
          if (err_q == '0) first_d = beat_q;
          if (err_q != '1) err_d   = err_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_ctrl_read) begin
      case (avs_ctrl_address)
        4'd0:    rdata_d = 32'h5c4ec4e2;
        4'd1:    rdata_d = 32'h00000100;
        4'd2:    rdata_d = '0;
        4'd3:    rdata_d = scratch_q;
        4'd4:    rdata_d = {30'd0, state_q == DONE, state_q == RUN};
        4'd5:    rdata_d = '0;
        4'd6:    rdata_d = {24'd0, p_q};
        4'd8:    rdata_d = target_q;
        4'd9:    rdata_d = rx_q;
        4'd10:   rdata_d = err_q;
        4'd11:   rdata_d = first_q;
        4'd12:   rdata_d = cyc_q;
        default: rdata_d = 32'hdeadbeef;
      endcase
    end
  end

  always_ff @(posedge csi_clk_clk or negedge rsi_reset_reset_n) begin
    if (!rsi_reset_reset_n) begin
      scratch_q <= '0;
      target_q  <= '0;
      p_q       <= '0;
      thr_q     <= '0;
      base_q    <= '0;
      rx_q      <= '0;
      err_q     <= '0;
      first_q   <= '1;
      cyc_q     <= '0;
      span_q    <= '0;
      beat_q    <= '0;
      active_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      scratch_q <= scratch_d;
      target_q  <= target_d;
      p_q       <= p_d;
      thr_q     <= thr_d;
      base_q    <= base_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      first_q   <= first_d;
      cyc_q     <= cyc_d;
      span_q    <= span_d;
      beat_q    <= beat_d;
      active_q  <= active_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avs_ctrl_readdata = rdata_q;

endmodule

// File: tb/tb_avalon_st_checker.sv
// Directed bench for avalon_st_checker: register map tables plus stream scenarios.
module tb_avalon_st_checker;

  localparam int unsigned DATA_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        addr = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       wdata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] data = '0;
  logic              valid = 1'b0;
  logic              ready;

  int n_chk = 0;
  int n_fail = 0;
  int ready_pat[16];
  int rp_n = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [31:0] status;
    logic [31:0] rx;
    logic [31:0] err;
    logic [31:0] first;
    logic [31:0] cyc;
  } res_vec_t;

  rd_vec_t  rst_tab[14];
  res_vec_t res_tab[6];

  avalon_st_checker #(.DATA_W(DATA_W)) dut (
    .csi_clk_clk        (clk),
    .rsi_reset_reset_n  (rst_n),
    .avs_ctrl_address   (addr),
    .avs_ctrl_read      (read),
    .avs_ctrl_write     (write),
    .avs_ctrl_writedata (wdata),
    .avs_ctrl_readdata  (readdata),
    .asi_data_data      (data),
    .asi_data_valid     (valid),
    .asi_data_ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    addr = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  function automatic logic [DATA_W-1:0] gen(input int b, input bit bad, input int lane);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'(b * 16 + i);
    if (bad) d[16*lane +: 16] = d[16*lane +: 16] ^ 16'h00ff;
    return d;
  endfunction

  // Source: holds valid, advances to the next beat after each handshake.
  task automatic stream(input int n, input int bad_beat, input int bad_lane, input bit keep_valid);
    int acc = 0;
    int cyc = 0;
    int src = 0;
    bit hs;
    valid = 1'b1;
    data  = gen(0, bad_beat == 0, bad_lane);
    while (acc < n && cyc < 2000) begin
      @(negedge clk);
      hs = ready && valid;
      if (rp_n < 16) begin
        ready_pat[rp_n] = int'(ready);
        rp_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        acc++;
        src++;
        data = gen(src, src == bad_beat, bad_lane);
      end
    end
    if (acc < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats expected %0d", acc, n);
    end
    if (!keep_valid) valid = 1'b0;
  endtask

  task automatic check_rst_tab();
    logic [31:0] d;
    for (int i = 0; i < 14; i++) begin
      rd(rst_tab[i].addr, d);
      check($sformatf("reg%0d", rst_tab[i].addr), d, rst_tab[i].exp);
    end
  endtask

  task automatic check_res(input int k);
    logic [31:0] d;
    rd(4'd4, d);  check($sformatf("t%0d_status", k), d, res_tab[k].status);
    rd(4'd9, d);  check($sformatf("t%0d_rx", k), d, res_tab[k].rx);
    rd(4'd10, d); check($sformatf("t%0d_err", k), d, res_tab[k].err);
    rd(4'd11, d); check($sformatf("t%0d_first", k), d, res_tab[k].first);
    rd(4'd12, d); check($sformatf("t%0d_cyc", k), d, res_tab[k].cyc);
  endtask

  initial begin
    logic [31:0] d;

    rst_tab = '{
      '{4'd0,  32'h5c4ec4e2}, '{4'd1,  32'h00000100}, '{4'd2,  32'h0},
      '{4'd3,  32'h0},        '{4'd4,  32'h0},        '{4'd5,  32'h0},
      '{4'd6,  32'h0},        '{4'd7,  32'hdeadbeef}, '{4'd8,  32'h0},
      '{4'd9,  32'h0},        '{4'd10, 32'h0},        '{4'd11, 32'hffffffff},
      '{4'd12, 32'h0},        '{4'd15, 32'hdeadbeef}
    };
    res_tab = '{
      '{32'd2, 32'h400, 32'd0, 32'hffffffff, 32'd32},  // clean run
      '{32'd2, 32'h400, 32'd1, 32'd5,        32'd32},  // beat 5 corrupted
      '{32'd2, 32'h100, 32'd0, 32'hffffffff, 32'd10},  // P = 3
      '{32'd2, 32'h0,   32'd0, 32'hffffffff, 32'd0},   // target 0
      '{32'd2, 32'h400, 32'd0, 32'hffffffff, 32'd32},  // after mid-run reset
      '{32'd2, 32'h400, 32'd0, 32'hffffffff, 32'd32}   // after restart
    };

    #2;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    #20 rst_n = 1'b1;

    check_rst_tab();

    wr(4'd3, 32'ha5a51234);
    rd(4'd3, d); check("scratch_rw", d, 32'ha5a51234);
    wr(4'd0, 32'h12345678);
    wr(4'd9, 32'h12345678);
    rd(4'd0, d); check("id_ro", d, 32'h5c4ec4e2);
    rd(4'd9, d); check("rx_ro", d, 32'h0);
    wr(4'd6, 32'h0000_0107);
    rd(4'd6, d); check("p_rw", d, 32'h7);
    wr(4'd6, 32'h0);

    // clean 32-beat run, then ready must stay low with valid held
    wr(4'd8, 32'h400);
    wr(4'd5, 32'h1);
    stream(32, -1, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_ready", 32'(ready), 32'd0);
    end
    valid = 1'b0;
    check_res(0);

    wr(4'd5, 32'h1);
    stream(32, 5, 3, 1'b0);
    check_res(1);

    // throttled run: expect ready 1,1,1,0 repeating
    wr(4'd6, 32'h3);
    wr(4'd8, 32'h100);
    rp_n = 0;
    wr(4'd5, 32'h1);
    stream(8, -1, 0, 1'b0);
    for (int i = 0; i < 10; i++)
      check($sformatf("thr_ready%0d", i), 32'(ready_pat[i]), (i % 4 == 3) ? 32'd0 : 32'd1);
    check_res(2);
    wr(4'd6, 32'h0);

    // target 0: RUN for one cycle with ready low, then DONE
    wr(4'd8, 32'h0);
    valid = 1'b1;
    data  = gen(0, 1'b0, 0);
    wr(4'd5, 32'h1);
    @(negedge clk); check("t0_ready_run", 32'(ready), 32'd0);
    @(negedge clk); check("t0_ready_done", 32'(ready), 32'd0);
    valid = 1'b0;
    check_res(3);

    // reset after 10 beats abandons the run
    wr(4'd8, 32'h400);
    wr(4'd5, 32'h1);
    stream(10, -1, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_readdata", readdata, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle_ready", 32'(ready), 32'd0);
    end
    valid = 1'b0;
    check_rst_tab();
    wr(4'd8, 32'h400);
    wr(4'd5, 32'h1);
    stream(32, -1, 0, 1'b0);
    check_res(4);

    // restart mid-run with valid high: the beat on the start edge is discarded
    wr(4'd5, 32'h1);
    stream(7, -1, 0, 1'b1);
    wr(4'd5, 32'h1);
    stream(32, -1, 0, 1'b0);
    check_res(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
